// File: rtl/fb_pixel_writer.sv
// Frame-buffer write stage: packs 8bpp pixels into 64-bit words, queues them and writes them out.
// Define FB_WRITER_DBLBUF_EN for front/back double buffering with a swap on every completed frame.
module fb_pixel_writer #(
  parameter int          FB_W       = 720,
  parameter int          FB_H       = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_data,
  input  logic        pix_first,
  output logic [28:0] fb_addr,
  output logic [63:0] fb_data,
  output logic        fb_req,
  input  logic        fb_ready,
  output logic        frame_done,
  output logic        resync,
  output logic [31:0] fb_base
);

  localparam int NUM_WORDS = FB_W * FB_H / 8;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [28:0]      BASE_WORD = BASE_ADDR[31:3];
`ifdef FB_WRITER_DBLBUF_EN
  localparam logic [28:0]      BUF_WORDS = 29'(NUM_WORDS);
  localparam logic [31:0]      BUF1_BASE = BASE_ADDR + 32'(FB_W * FB_H);
`endif

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic               r_live;
  logic [2:0]         r_packCnt;
  logic [55:0]        r_packWord;
  logic [IDX_W-1:0]   r_wordIdx;
  logic [63:0]        r_memData [FIFO_DEPTH];
  logic [IDX_W-1:0]   r_memIdx  [FIFO_DEPTH];
  logic [PTR_W:0]     r_wrPtr;
  logic [PTR_W:0]     r_rdPtr;
  logic [28:0]        r_fbAddr;
  logic [63:0]        r_fbData;
  logic [IDX_W-1:0]   r_headIdx;
  logic               r_frameDone;
  logic               r_resync;

  logic [PTR_W:0]     w_count;
  logic [PTR_W:0]     w_rdNext;
  logic               w_full;
  logic               w_empty;
  logic               w_pixAccept;
  logic               w_aligned;
  logic               w_realign;
  logic               w_push;
  logic [63:0]        w_pushData;
  logic               w_pop;
  logic               w_lastPop;
  logic               w_load;
  logic [63:0]        w_loadData;
  logic [IDX_W-1:0]   w_loadIdx;
  logic [28:0]        w_loadAddr;

  assign w_count     = r_wrPtr - r_rdPtr;
  assign w_rdNext    = r_rdPtr + 1'b1;
  assign w_full      = (w_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty     = (w_count == '0);
  assign pix_ready   = r_live & ~(w_full & (r_packCnt == 3'd7));
  assign w_pixAccept = pix_valid & pix_ready;
  assign w_aligned   = (r_packCnt == 3'd0) && (r_wordIdx == '0);
  assign w_realign   = w_pixAccept & pix_first & ~w_aligned;
  assign w_push      = w_pixAccept & ~w_realign & (r_packCnt == 3'd7);
  assign w_pushData  = {pix_data, r_packWord};
  assign w_pop       = (r_state == S_REQ) & fb_ready;
  assign w_lastPop   = w_pop & (r_headIdx == LAST_IDX);

  // pix_ready stays low until the first clock after reset is released
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_packCnt  <= 3'd0;
      r_packWord <= '0;
      r_wordIdx  <= '0;
      r_resync   <= 1'b0;
    end else begin
      r_resync <= w_realign;
      if (w_pixAccept) begin
        if (w_realign) begin
          r_packWord[7:0] <= pix_data;
          r_packCnt       <= 3'd1;
          r_wordIdx       <= '0;
        end else if (r_packCnt == 3'd7) begin
          r_packCnt <= 3'd0;
          r_wordIdx <= (r_wordIdx == LAST_IDX) ? '0 : r_wordIdx + 1'b1;
        end else begin
          for (int n = 0; n < 7; n++) begin
            if (r_packCnt == 3'(n)) r_packWord[8*n +: 8] <= pix_data;
          end
          r_packCnt <= r_packCnt + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_memData[r_wrPtr[PTR_W-1:0]] <= w_pushData;
      r_memIdx[r_wrPtr[PTR_W-1:0]]  <= r_wordIdx;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= w_rdNext;
    end
  end

  // A word pushed on the same edge as the last pop is forwarded so REQ never gaps
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_loadData  = r_memData[r_rdPtr[PTR_W-1:0]];
    w_loadIdx   = r_memIdx[r_rdPtr[PTR_W-1:0]];
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_nextState = S_REQ;
        end
      end
      S_REQ: begin
        if (fb_ready) begin
          if (w_count > (PTR_W+1)'(1)) begin
            w_load     = 1'b1;
            w_loadData = r_memData[w_rdNext[PTR_W-1:0]];
            w_loadIdx  = r_memIdx[w_rdNext[PTR_W-1:0]];
          end else if (w_push) begin
            w_load     = 1'b1;
            w_loadData = w_pushData;
            w_loadIdx  = r_wordIdx;
          end else begin
            w_nextState = S_IDLE;
          end
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

`ifdef FB_WRITER_DBLBUF_EN
  logic r_backSel;
  logic r_fbBaseSel;
  logic w_loadSel;

  // A word loaded on the edge that completes a frame already belongs to the other buffer
  assign w_loadSel  = r_backSel ^ w_lastPop;
  assign w_loadAddr = BASE_WORD + 29'(w_loadIdx) + (w_loadSel ? BUF_WORDS : 29'd0);
  assign fb_base    = r_fbBaseSel ? BUF1_BASE : BASE_ADDR;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_backSel   <= 1'b0;
      r_fbBaseSel <= 1'b0;
    end else if (w_lastPop) begin
      r_backSel   <= ~r_backSel;
      r_fbBaseSel <= r_backSel;
    end
  end
`else
  assign w_loadAddr = BASE_WORD + 29'(w_loadIdx);
  assign fb_base    = BASE_ADDR;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_fbAddr    <= '0;
      r_fbData    <= '0;
      r_headIdx   <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_frameDone <= w_lastPop;
      if (w_load) begin
        r_fbAddr  <= w_loadAddr;
        r_fbData  <= w_loadData;
        r_headIdx <= w_loadIdx;
      end
    end
  end

  assign fb_req     = (r_state == S_REQ);
  assign fb_addr    = r_fbAddr;
  assign fb_data    = r_fbData;
  assign frame_done = r_frameDone;
  assign resync     = r_resync;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer on a reduced 16x4 frame (8 words per frame).
// Expectations follow FB_WRITER_DBLBUF_EN when it is defined for the build.
module tb_fb_pixel_writer;

  localparam logic [28:0] BASE_WORD = 29'h600_0000;
`ifdef FB_WRITER_DBLBUF_EN
  localparam logic [28:0] FRAME2_WORD = 29'h600_0008;
  localparam logic [31:0] BASE_AFTER2 = 32'h3000_0040;
`else
  localparam logic [28:0] FRAME2_WORD = 29'h600_0000;
  localparam logic [31:0] BASE_AFTER2 = 32'h3000_0000;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic        pix_first;
  logic [28:0] fb_addr;
  logic [63:0] fb_data;
  logic        fb_req;
  logic        fb_ready;
  logic        frame_done;
  logic        resync;
  logic [31:0] fb_base;

  int nAsserts = 0;
  int nFailures = 0;
  int frameDoneCnt = 0;
  int resyncCnt = 0;
  logic [28:0] qAddr[$];
  logic [63:0] qData[$];

  fb_pixel_writer #(
    .FB_W(16), .FB_H(4), .BASE_ADDR(32'h3000_0000), .FIFO_DEPTH(4)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_first(pix_first),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_req(fb_req), .fb_ready(fb_ready),
    .frame_done(frame_done), .resync(resync), .fb_base(fb_base)
  );

  always #5 clk_sys = ~clk_sys;

  // Inputs change just after the rising edge, so the falling edge sees what the next rising edge will take
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (fb_req && fb_ready) begin
        qAddr.push_back(fb_addr);
        qData.push_back(fb_data);
      end
      if (frame_done) frameDoneCnt++;
      if (resync) resyncCnt++;
    end
  end

  function automatic logic [63:0] wordData(input logic [7:0] firstPix);
    logic [63:0] d;
    for (int n = 0; n < 8; n++) d[8*n +: 8] = firstPix + 8'(n);
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFailures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic first);
    int waitCycles;
    pix_valid = 1'b1;
    pix_data  = data;
    pix_first = first;
    waitCycles = 0;
    @(negedge clk_sys);
    while (!pix_ready && waitCycles < 500) begin
      @(negedge clk_sys);
      waitCycles++;
    end
    if (!pix_ready) begin
      nAsserts++;
      nFailures++;
      $error("[TB] FAIL pixel_accept: pix_ready observed 0 expected 1 after 500 cycles");
    end
    @(posedge clk_sys);
    #1;
    pix_valid = 1'b0;
    pix_first = 1'b0;
  endtask

  task automatic expectWrite(input string tag, input logic [28:0] addr, input logic [63:0] data);
    int waitCycles;
    waitCycles = 0;
    while (qAddr.size() == 0 && waitCycles < 300) begin
      @(negedge clk_sys);
      #1;
      waitCycles++;
    end
    if (qAddr.size() == 0) begin
      nAsserts++;
      nFailures++;
      $error("[TB] FAIL %s: no write observed, expected addr %h", tag, addr);
    end else begin
      checkOutput({tag, "_addr"}, 64'(qAddr.pop_front()), 64'(addr));
      checkOutput({tag, "_data"}, qData.pop_front(), data);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 8'h00;
    pix_first = 1'b0;
    fb_ready  = 1'b0;

    // Reset held with stimulus toggling
    repeat (4) begin
      step(1);
      pix_valid = ~pix_valid;
      pix_first = ~pix_first;
      pix_data  = pix_data + 8'h11;
      fb_ready  = ~fb_ready;
    end
    @(negedge clk_sys);
    checkOutput("rst_fb_req", fb_req, 0);
    checkOutput("rst_pix_ready", pix_ready, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_fb_base", fb_base, 32'h3000_0000);
    checkOutput("rst_fb_addr", fb_addr, 0);
    step(1);
    pix_valid = 1'b0;
    pix_first = 1'b0;
    fb_ready  = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk_sys);
    checkOutput("rel_pix_ready_0", pix_ready, 0);
    @(negedge clk_sys);
    checkOutput("rel_pix_ready_1", pix_ready, 1);
    step(1);
    fb_ready = 1'b1;

    // First word and request latency
    for (int p = 0; p < 8; p++) applyStimulus(8'(p), p == 0);
    @(negedge clk_sys);
    checkOutput("lat_req_t1", fb_req, 0);
    @(negedge clk_sys);
    checkOutput("lat_req_t2", fb_req, 1);
    checkOutput("w0_fb_addr", fb_addr, 64'(BASE_WORD));
    checkOutput("w0_fb_data", fb_data, 64'h0706050403020100);
    expectWrite("w0", BASE_WORD, 64'h0706050403020100);

    // Backpressure: four words queued plus seven packed pixels
    step(1);
    fb_ready = 1'b0;
    for (int p = 8; p < 47; p++) applyStimulus(8'(p), 1'b0);
    @(negedge clk_sys);
    checkOutput("bp_pix_ready", pix_ready, 0);
    checkOutput("bp_fb_req", fb_req, 1);
    checkOutput("bp_fb_addr", fb_addr, 64'(BASE_WORD + 29'd1));
    repeat (10) @(negedge clk_sys);
    checkOutput("bp_pix_ready_hold", pix_ready, 0);
    checkOutput("bp_no_writes", qAddr.size(), 0);
    step(1);
    fb_ready = 1'b1;
    for (int p = 47; p < 64; p++) applyStimulus(8'(p), 1'b0);
    for (int w = 1; w < 8; w++) expectWrite($sformatf("f1_w%0d", w), BASE_WORD + 29'(w), wordData(8'(8 * w)));
    step(3);
    checkOutput("f1_frame_done_cnt", frameDoneCnt, 1);
    checkOutput("f1_fb_base", fb_base, 32'h3000_0000);
    checkOutput("f1_resync_cnt", resyncCnt, 0);

    // Second frame starts at word 0 of its buffer
    for (int p = 0; p < 64; p++) applyStimulus(8'(p), p == 0);
    for (int w = 0; w < 8; w++) expectWrite($sformatf("f2_w%0d", w), FRAME2_WORD + 29'(w), wordData(8'(8 * w)));
    step(3);
    checkOutput("f2_frame_done_cnt", frameDoneCnt, 2);
    checkOutput("f2_fb_base", fb_base, BASE_AFTER2);

    // Misaligned pix_first on lane 5 of word 3
    for (int p = 0; p < 29; p++) applyStimulus(8'(p), p == 0);
    applyStimulus(8'hA5, 1'b1);
    for (int k = 0; k < 7; k++) applyStimulus(8'hB0 + 8'(k), 1'b0);
    for (int w = 0; w < 3; w++) expectWrite($sformatf("f3_w%0d", w), BASE_WORD + 29'(w), wordData(8'(8 * w)));
    expectWrite("f3_resync_w0", BASE_WORD, 64'hB6B5B4B3B2B1B0A5);
    step(5);
    checkOutput("f3_resync_cnt", resyncCnt, 1);
    checkOutput("f3_no_partial", qAddr.size(), 0);
    checkOutput("f3_frame_done_cnt", frameDoneCnt, 2);

    // Reset asserted while a write is pending
    fb_ready = 1'b0;
    for (int k = 0; k < 8; k++) applyStimulus(8'h40 + 8'(k), 1'b0);
    step(3);
    checkOutput("mid_fb_req_high", fb_req, 1);
    @(negedge clk_sys);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_fb_req", fb_req, 0);
    checkOutput("mid_rst_fb_base", fb_base, 32'h3000_0000);
    checkOutput("mid_rst_pix_ready", pix_ready, 0);
    checkOutput("mid_rst_fb_addr", fb_addr, 0);
    step(2);
    reset_n = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFailures);
    $finish;
  end

endmodule
